dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core load/store
// port (r0) and the loader/debug port (r1). One transaction is in flight at a
// time: grant -> ISSUE (mem_en) -> WAIT (latency) -> RESP (rvalid).
//
// Handshake: a requester raises req with we/addrmode/addr/wdata stable and
// holds them until it sees its gnt pulse; gnt is combinational in the IDLE or
// RESP cycle and the fields are captured on that clock edge. Exactly one
// rvalid pulse follows each gnt, MEM_LATENCY+1 cycles later; rdata is only
// meaningful (and only non-zero) for reads in that cycle.
//
// Optional build macro ARB_FIXED_PRIO_EN: r0 has fixed priority with a
// starvation counter that forces r1 after STARVE_LIMIT contended r0 wins.
// Without it, contended requests alternate round-robin.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic                  r0_addrmode,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic                  r1_addrmode,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_addrmode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wide enough for MEM_LATENCY-1 up to 3.
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic             lat_id;      // 0 = r0 owns the transaction, 1 = r1
    logic             lat_we;
    logic             arb_window;
    logic             any_req;
    logic             contended;
    logic             pick_r1;
    logic             grant;

`ifdef ARB_FIXED_PRIO_EN
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;
`else
    logic last_winner;             // 0 = r0 won last, 1 = r1 won last
`endif

    assign arb_window = (state == IDLE) || (state == RESP);
    assign any_req    = r0_req | r1_req;
    assign contended  = r0_req & r1_req;
    // Reset gates the grant so nothing is accepted while rst is low.
    assign grant      = arb_window & any_req & rst;
    assign r0_gnt     = grant & ~pick_r1;
    assign r1_gnt     = grant & pick_r1;

    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    // Read data passes through only during a read completion.
    assign r0_rdata = (r0_rvalid && !lat_we) ? mem_rdata : '0;
    assign r1_rdata = (r1_rvalid && !lat_we) ? mem_rdata : '0;

    // Arbitration: a lone requester wins; contention resolved by policy.
    always_comb begin
        pick_r1 = r1_req & ~r0_req;
        if (contended) begin
`ifdef ARB_FIXED_PRIO_EN
            pick_r1 = (starve_cnt == STARVE_MAX);
`else
            pick_r1 = (last_winner == 1'b0);
`endif
        end
    end

    // Transaction sequencer with registered memory strobes and completions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            lat_id       <= 1'b0;
            lat_we       <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addrmode <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            r0_rvalid    <= 1'b0;
            r1_rvalid    <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
            starve_cnt   <= '0;
`else
            last_winner  <= 1'b1;
`endif
        end else begin
            // Strobes are single-cycle; the memory bus idles at zero.
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addrmode <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            r0_rvalid    <= 1'b0;
            r1_rvalid    <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (grant) begin
                        lat_id       <= pick_r1;
                        lat_we       <= pick_r1 ? r1_we : r0_we;
                        mem_en       <= 1'b1;
                        mem_we       <= pick_r1 ? r1_we : r0_we;
                        mem_addrmode <= pick_r1 ? r1_addrmode : r0_addrmode;
                        mem_addr     <= pick_r1 ? r1_addr : r0_addr;
                        mem_wdata    <= pick_r1 ? r1_wdata : r0_wdata;
`ifdef ARB_FIXED_PRIO_EN
                        if (contended && !pick_r1) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
`else
                        last_winner  <= pick_r1;
`endif
                        state        <= ISSUE;
                    end else begin
                        state        <= IDLE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    if (MEM_LATENCY > 1) begin
                        state <= WAIT;
                    end else begin
                        state     <= RESP;
                        r0_rvalid <= ~lat_id;
                        r1_rvalid <= lat_id;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt <= 1) begin
                        state     <= RESP;
                        r0_rvalid <= ~lat_id;
                        r1_rvalid <= lat_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three lanes with MEM_LATENCY 1, 3 and 4, each with
// its own memory model. Directed scenarios plus randomized traffic checked
// against a transaction-level reference (grant cycle -> issue at +1 ->
// completion at +1+latency, reference memory, arbitration policy).
module tb_dmem_arbiter;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int NL     = 3;
  localparam int STARVE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          r0_req [NL], r1_req [NL], r0_we [NL], r1_we [NL];
  logic          r0_am [NL], r1_am [NL];
  logic [AW-1:0] r0_addr [NL], r1_addr [NL];
  logic [DW-1:0] r0_wdata [NL], r1_wdata [NL];
  logic          r0_gnt [NL], r1_gnt [NL], r0_rvalid [NL], r1_rvalid [NL];
  logic [DW-1:0] r0_rdata [NL], r1_rdata [NL];
  logic          mem_en [NL], mem_we [NL], mem_am [NL], busy [NL];
  logic [AW-1:0] mem_addr [NL];
  logic [DW-1:0] mem_wdata [NL], mem_rdata [NL];
  logic [1:0]    dbg_state [NL];

  logic [DW-1:0] mem_arr [NL][256];
  logic [DW-1:0] ref_mem [NL][256];

  int checks = 0;
  int errors = 0;
  int m_lw;
  int m_starve;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    dmem_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE)
    ) u_dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req[g]), .r0_we(r0_we[g]), .r0_addrmode(r0_am[g]),
      .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
      .r0_gnt(r0_gnt[g]), .r0_rvalid(r0_rvalid[g]), .r0_rdata(r0_rdata[g]),
      .r1_req(r1_req[g]), .r1_we(r1_we[g]), .r1_addrmode(r1_am[g]),
      .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
      .r1_gnt(r1_gnt[g]), .r1_rvalid(r1_rvalid[g]), .r1_rdata(r1_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addrmode(mem_am[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .dbg_state(dbg_state[g])
    );
  end

  // Memory models: capture read data on the mem_en edge, hold until next access.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (mem_en[i]) begin
        if (mem_we[i]) mem_arr[i][mem_addr[i][7:0]] <= mem_wdata[i];
        else           mem_rdata[i] <= mem_arr[i][mem_addr[i][7:0]];
      end
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // Reference arbitration policy; returns 0 for r0, 1 for r1.
  function automatic int pick(input logic a, input logic b);
    int w;
`ifdef ARB_FIXED_PRIO_EN
    if (a && b) begin
      if (m_starve == STARVE) begin w = 1; m_starve = 0; end
      else begin w = 0; m_starve = m_starve + 1; end
    end else begin
      w = b ? 1 : 0;
      m_starve = 0;
    end
`else
    if (a && b) w = (m_lw == 0) ? 1 : 0;
    else        w = b ? 1 : 0;
`endif
    m_lw = w;
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NL; k++) begin
      r0_req[k] = 0; r1_req[k] = 0; r0_we[k] = 0; r1_we[k] = 0;
      r0_am[k] = 0; r1_am[k] = 0; r0_addr[k] = '0; r1_addr[k] = '0;
      r0_wdata[k] = '0; r1_wdata[k] = '0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (3) cyc();
    rst = 1'b1;
    m_lw = 1;
    m_starve = 0;
  endtask

  task automatic do_write(input int k, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n;
    cyc();
    r0_req[k] = 1; r0_we[k] = 1; r0_am[k] = 0; r0_addr[k] = addr; r0_wdata[k] = data;
    #1;
    n = 0;
    while (!r0_gnt[k] && n < 20) begin cyc(); #1; n++; end
    checks++;
    if (r0_gnt[k] !== 1'b1) begin errors++; $display("FAIL wr_gnt_timeout lane=%0d got=%0b exp=1", k, r0_gnt[k]); end
    cyc();
    r0_req[k] = 0; r0_we[k] = 0;
    #1;
    n = 0;
    while (!r0_rvalid[k] && n < 20) begin cyc(); #1; n++; end
    checks++;
    if (r0_rvalid[k] !== 1'b1) begin errors++; $display("FAIL wr_rvalid_timeout lane=%0d got=%0b exp=1", k, r0_rvalid[k]); end
    ref_mem[k][addr[7:0]] = data;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b0;
    r0_req[0] = 1;
    #1;
    checks++;
    if ({r0_gnt[0], r1_gnt[0], mem_en[0], mem_we[0], busy[0], r0_rvalid[0], r1_rvalid[0]} !== 7'b0) begin
      errors++; $display("FAIL rst_ctrl got=%b exp=0", {r0_gnt[0], r1_gnt[0], mem_en[0], mem_we[0], busy[0], r0_rvalid[0], r1_rvalid[0]});
    end
    checks++;
    if ({mem_addr[0], mem_wdata[0], r0_rdata[0]} !== '0) begin
      errors++; $display("FAIL rst_data got=%h exp=0", {mem_addr[0], mem_wdata[0], r0_rdata[0]});
    end
    cyc(); #1;
    checks++;
    if (r0_gnt[0] !== 1'b0) begin errors++; $display("FAIL rst_held_gnt got=%0b exp=0", r0_gnt[0]); end
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (r0_gnt[0] !== 1'b1 || r1_gnt[0] !== 1'b0) begin
      errors++; $display("FAIL rst_release_gnt got=%0b%0b exp=10", r0_gnt[0], r1_gnt[0]);
    end
    cyc();
    r0_req[0] = 0;
    #1;
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b0) begin
      errors++; $display("FAIL rst_first_issue got=%0b%0b exp=10", mem_en[0], mem_we[0]);
    end
    repeat (3) cyc();
  endtask

  task automatic test_write_l1();
    cyc();
    r0_req[0] = 1; r0_we[0] = 1; r0_am[0] = 0; r0_addr[0] = 32'h10; r0_wdata[0] = 32'hDEADBEEF;
    #1;
    checks++;
    if (r0_gnt[0] !== 1'b1 || r1_gnt[0] !== 1'b0) begin
      errors++; $display("FAIL wr_gnt got=%0b%0b exp=10", r0_gnt[0], r1_gnt[0]);
    end
    cyc();
    r0_req[0] = 0; r0_we[0] = 0;
    #1;
    checks++;
    if ({mem_en[0], mem_we[0], mem_am[0], mem_addr[0], mem_wdata[0]} !== {3'b110, 32'h10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_issue got=%b/%h/%h exp=110/10/deadbeef",
                         {mem_en[0], mem_we[0], mem_am[0]}, mem_addr[0], mem_wdata[0]);
    end
    checks++;
    if (busy[0] !== 1'b1 || r0_rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL wr_issue_busy got=%0b%0b exp=10", busy[0], r0_rvalid[0]);
    end
    ref_mem[0][8'h10] = 32'hDEADBEEF;
    cyc(); #1;
    checks++;
    if (r0_rvalid[0] !== 1'b1 || r1_rvalid[0] !== 1'b0 || r0_rdata[0] !== '0) begin
      errors++; $display("FAIL wr_resp got=%0b%0b/%h exp=10/0", r0_rvalid[0], r1_rvalid[0], r0_rdata[0]);
    end
    checks++;
    if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]} !== '0) begin
      errors++; $display("FAIL wr_bus_idle got=%b/%h/%h exp=0", {mem_en[0], mem_we[0]}, mem_addr[0], mem_wdata[0]);
    end
    cyc(); #1;
    checks++;
    if (busy[0] !== 1'b0 || r0_rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL wr_after got=%0b%0b exp=00", busy[0], r0_rvalid[0]);
    end
  endtask

  task automatic test_read_l3();
    do_write(1, 32'h10, 32'hDEADBEEF);
    cyc();
    r1_req[1] = 1; r1_we[1] = 0; r1_am[1] = 0; r1_addr[1] = 32'h10;
    #1;
    checks++;
    if (r1_gnt[1] !== 1'b1 || r0_gnt[1] !== 1'b0) begin
      errors++; $display("FAIL rd_gnt got=%0b%0b exp=01", r0_gnt[1], r1_gnt[1]);
    end
    cyc();
    r1_req[1] = 0;
    #1;
    checks++;
    if (mem_en[1] !== 1'b1 || mem_we[1] !== 1'b0 || mem_addr[1] !== 32'h10) begin
      errors++; $display("FAIL rd_issue got=%0b%0b/%h exp=10/10", mem_en[1], mem_we[1], mem_addr[1]);
    end
    for (int i = 2; i <= 3; i++) begin
      cyc(); #1;
      checks++;
      if (mem_en[1] !== 1'b0 || r1_rvalid[1] !== 1'b0 || busy[1] !== 1'b1) begin
        errors++; $display("FAIL rd_wait t=%0d got=%0b%0b%0b exp=001", i, mem_en[1], r1_rvalid[1], busy[1]);
      end
    end
    cyc(); #1;
    checks++;
    if (r1_rvalid[1] !== 1'b1 || r1_rdata[1] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_resp got=%0b/%h exp=1/deadbeef", r1_rvalid[1], r1_rdata[1]);
    end
    checks++;
    if (r0_rvalid[1] !== 1'b0 || r0_rdata[1] !== '0) begin
      errors++; $display("FAIL rd_other got=%0b/%h exp=0/0", r0_rvalid[1], r0_rdata[1]);
    end
    cyc(); #1;
    checks++;
    if (r1_rvalid[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL rd_after got=%0b%0b exp=00", r1_rvalid[1], busy[1]);
    end
  endtask

  task automatic test_contention();
    int w;
    logic gv;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cyc();
      r0_req[0] = 1; r0_addr[0] = 32'h04;
      r1_req[0] = 1; r1_addr[0] = 32'h08;
      #1;
      gv = (c % 2 == 0);
      w = gv ? pick(1'b1, 1'b1) : 0;
      checks++;
      if (r0_gnt[0] !== (gv && w == 0) || r1_gnt[0] !== (gv && w == 1)) begin
        errors++; $display("FAIL cont_gnt c=%0d got=%0b%0b exp=%0b%0b", c, r0_gnt[0], r1_gnt[0], gv && w == 0, gv && w == 1);
      end
      checks++;
      if ((r0_gnt[0] && r1_gnt[0]) !== 1'b0) begin
        errors++; $display("FAIL cont_double c=%0d got=1 exp=0", c);
      end
    end
    cyc();
    r0_req[0] = 0; r1_req[0] = 0;
    repeat (4) cyc();
  endtask

  task automatic test_midop_reset();
    cyc();
    r0_req[2] = 1; r0_we[2] = 0; r0_addr[2] = 32'h20;
    #1;
    checks++;
    if (r0_gnt[2] !== 1'b1) begin errors++; $display("FAIL mid_gnt got=%0b exp=1", r0_gnt[2]); end
    cyc();
    r0_req[2] = 0;
    #1;
    checks++;
    if (mem_en[2] !== 1'b1) begin errors++; $display("FAIL mid_issue got=%0b exp=1", mem_en[2]); end
    cyc(); #1;
    checks++;
    if (busy[2] !== 1'b1 || mem_en[2] !== 1'b0) begin
      errors++; $display("FAIL mid_wait got=%0b%0b exp=10", busy[2], mem_en[2]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy[2], mem_en[2], mem_we[2], r0_rvalid[2], r1_rvalid[2], r0_gnt[2], dbg_state[2]} !== 8'b0) begin
      errors++; $display("FAIL mid_rst_outputs got=%b exp=0",
                         {busy[2], mem_en[2], mem_we[2], r0_rvalid[2], r1_rvalid[2], r0_gnt[2], dbg_state[2]});
    end
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      checks++;
      if (r0_rvalid[2] !== 1'b0 || r1_rvalid[2] !== 1'b0) begin
        errors++; $display("FAIL mid_no_rvalid i=%0d got=%0b%0b exp=00", i, r0_rvalid[2], r1_rvalid[2]);
      end
    end
    cyc();
    rst = 1'b1;
    m_lw = 1;
    m_starve = 0;
    #1;
    checks++;
    if (busy[2] !== 1'b0) begin errors++; $display("FAIL mid_release_idle got=%0b exp=0", busy[2]); end
    cyc();
    r1_req[2] = 1; r1_we[2] = 0; r1_addr[2] = 32'h30;
    #1;
    checks++;
    if (r1_gnt[2] !== 1'b1) begin errors++; $display("FAIL mid_new_gnt got=%0b exp=1", r1_gnt[2]); end
    cyc();
    r1_req[2] = 0;
    #1;
    checks++;
    if (mem_en[2] !== 1'b1 || mem_addr[2] !== 32'h30) begin
      errors++; $display("FAIL mid_new_issue got=%0b/%h exp=1/30", mem_en[2], mem_addr[2]);
    end
    for (int i = 2; i <= 4; i++) begin
      cyc(); #1;
      checks++;
      if (r1_rvalid[2] !== 1'b0 || busy[2] !== 1'b1) begin
        errors++; $display("FAIL mid_new_wait t=%0d got=%0b%0b exp=01", i, r1_rvalid[2], busy[2]);
      end
    end
    cyc(); #1;
    checks++;
    if (r1_rvalid[2] !== 1'b1 || r1_rdata[2] !== ref_mem[2][8'h30]) begin
      errors++; $display("FAIL mid_new_resp got=%0b/%h exp=1/%h", r1_rvalid[2], r1_rdata[2], ref_mem[2][8'h30]);
    end
    cyc(); #1;
    checks++;
    if (r1_rvalid[2] !== 1'b0) begin errors++; $display("FAIL mid_new_after got=%0b exp=0", r1_rvalid[2]); end
  endtask

  task automatic test_random(input int k, input int n);
    int lat, w, t_issue, t_resp, next_ok, t_who;
    logic pend [2], p_we [2], p_am [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd [2];
    logic has_txn, t_we, t_am, e_iss, e_resp, e_busy, gv;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wd, t_rd, e_rd0, e_rd1;
    logic [AW+DW+1:0] e_bus;
    lat = lat_of(k);
    apply_reset();
    has_txn = 0; next_ok = 0; t_issue = 0; t_resp = 0; t_who = 0;
    t_we = 0; t_am = 0; t_addr = '0; t_wd = '0; t_rd = '0;
    for (int j = 0; j < 2; j++) begin
      pend[j] = 0; p_we[j] = 0; p_am[j] = 0; p_addr[j] = '0; p_wd[j] = '0;
    end
    for (int c = 0; c < n; c++) begin
      cyc();
      for (int j = 0; j < 2; j++) begin
        if (!pend[j] && c < n - 12 && $urandom_range(0, 2) != 0) begin
          pend[j]   = 1;
          p_we[j]   = 1'($urandom_range(0, 1));
          p_am[j]   = 1'($urandom_range(0, 1));
          p_addr[j] = AW'($urandom_range(0, 63) * 4);
          p_wd[j]   = $urandom;
        end
      end
      r0_req[k] = pend[0]; r0_we[k] = p_we[0]; r0_am[k] = p_am[0]; r0_addr[k] = p_addr[0]; r0_wdata[k] = p_wd[0];
      r1_req[k] = pend[1]; r1_we[k] = p_we[1]; r1_am[k] = p_am[1]; r1_addr[k] = p_addr[1]; r1_wdata[k] = p_wd[1];
      #1;
      e_iss  = has_txn && c == t_issue;
      e_resp = has_txn && c == t_resp;
      e_busy = has_txn && c >= t_issue && c <= t_resp;
      if (e_iss) begin
        if (t_we) ref_mem[k][t_addr[7:0]] = t_wd;
        else      t_rd = ref_mem[k][t_addr[7:0]];
      end
      e_bus = e_iss ? {t_we, t_am, t_addr, t_wd} : '0;
      e_rd0 = (e_resp && t_who == 0 && !t_we) ? t_rd : '0;
      e_rd1 = (e_resp && t_who == 1 && !t_we) ? t_rd : '0;
      checks++;
      if (mem_en[k] !== e_iss) begin
        errors++; $display("FAIL rnd_mem_en lane=%0d c=%0d got=%0b exp=%0b", k, c, mem_en[k], e_iss);
      end
      checks++;
      if ({mem_we[k], mem_am[k], mem_addr[k], mem_wdata[k]} !== e_bus) begin
        errors++; $display("FAIL rnd_mem_bus lane=%0d c=%0d got=%h exp=%h", k, c,
                           {mem_we[k], mem_am[k], mem_addr[k], mem_wdata[k]}, e_bus);
      end
      checks++;
      if (busy[k] !== e_busy) begin
        errors++; $display("FAIL rnd_busy lane=%0d c=%0d got=%0b exp=%0b", k, c, busy[k], e_busy);
      end
      checks++;
      if (r0_rvalid[k] !== (e_resp && t_who == 0) || r1_rvalid[k] !== (e_resp && t_who == 1)) begin
        errors++; $display("FAIL rnd_rvalid lane=%0d c=%0d got=%0b%0b exp=%0b%0b", k, c,
                           r0_rvalid[k], r1_rvalid[k], e_resp && t_who == 0, e_resp && t_who == 1);
      end
      checks++;
      if (r0_rdata[k] !== e_rd0 || r1_rdata[k] !== e_rd1) begin
        errors++; $display("FAIL rnd_rdata lane=%0d c=%0d got=%h/%h exp=%h/%h", k, c,
                           r0_rdata[k], r1_rdata[k], e_rd0, e_rd1);
      end
      gv = (c >= next_ok) && (pend[0] || pend[1]);
      w = gv ? pick(pend[0], pend[1]) : 0;
      checks++;
      if (r0_gnt[k] !== (gv && w == 0) || r1_gnt[k] !== (gv && w == 1)) begin
        errors++; $display("FAIL rnd_gnt lane=%0d c=%0d got=%0b%0b exp=%0b%0b", k, c,
                           r0_gnt[k], r1_gnt[k], gv && w == 0, gv && w == 1);
      end
      if (gv) begin
        has_txn = 1; t_issue = c + 1; t_resp = c + 1 + lat; next_ok = t_resp; t_who = w;
        t_we = p_we[w]; t_am = p_am[w]; t_addr = p_addr[w]; t_wd = p_wd[w];
        pend[w] = 0;
      end
    end
    clear_inputs();
    cyc();
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      for (int j = 0; j < 256; j++) begin
        mem_arr[i][j] <= (32'(j) * 32'h01010101) ^ 32'hA5000000;
        ref_mem[i][j] = (32'(j) * 32'h01010101) ^ 32'hA5000000;
      end
    end
    apply_reset();
    test_reset();
    test_write_l1();
    test_read_l3();
    test_contention();
    test_midop_reset();
    test_random(0, 160);
    test_random(1, 160);
    test_random(2, 160);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
